lsu_mem_master: RTL and testbench

- Load/store requester that drives the physical-memory port from the core's memory stage.
- Accepts one load or store per transaction from the execute/memory pipeline and issues a word-aligned request to memory. Memory may take any number of cycles.
- Loads: returns a sign- or zero-extended result. Stores: produces the byte-lane write data and write mask.
- Replaces direct combinational memory access with a registered valid/ready handshake on both sides.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_mem_master_if.sv | 53 +++++
 rtl/lsu_lane_align.sv | 53 +++++
 rtl/lsu_mem_master.sv | 169 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings, FSM
// state type, byte-lane mask constants and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // True when the access cannot be issued: illegal size, or an address
  // that is not naturally aligned for the requested size.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    access_bad = 1'b0;
      SZ_H:    access_bad = off[0];
      SZ_W:    access_bad = |off;
      default: access_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Bus bundles for the load/store unit.
// lsu_req_if: core-side request/response; the core is master, the LSU slave.
// lsu_mem_if: memory-side port; the LSU is master, the memory slave.
interface lsu_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_size;
  logic              req_sext;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_sext, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_sext, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for the LSU: store data replication and
// write mask generation, plus load word shifting and sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wmask_o,
  input  logic [1:0]  ld_off_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_sext_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shift;

  // Store side: replicate the right-aligned data into every lane so the
  // mask alone selects which bytes memory writes.
  always_comb begin
    st_wdata_o = st_wdata_i;
    st_wmask_o = MASK_W;
    case (st_size_i)
      SZ_B: begin
        st_wdata_o = {4{st_wdata_i[7:0]}};
        st_wmask_o = MASK_B << st_off_i;
      end
      SZ_H: begin
        st_wdata_o = {2{st_wdata_i[15:0]}};
        st_wmask_o = MASK_H << st_off_i;
      end
      default: begin
        st_wdata_o = st_wdata_i;
        st_wmask_o = MASK_W;
      end
    endcase
  end

  assign ld_shift = ld_rdata_i >> {ld_off_i, 3'b000};

  // Load side: bring the addressed bytes down to bit 0, then extend.
  always_comb begin
    ld_data_o = ld_shift;
    case (ld_size_i)
      SZ_B:    ld_data_o = {{24{ld_sext_i & ld_shift[7]}}, ld_shift[7:0]};
      SZ_H:    ld_data_o = {{16{ld_sext_i & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data_o = ld_shift;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store requester between the core memory stage and the memory port.
// One transaction in flight: accept in IDLE, issue in REQ, wait for read
// data in WAIT_R, hold the response in RESP until the core takes it.
// Optional feature: define LSU_TIMEOUT_EN to bound the memory wait to
// TIMEOUT_CYCLES cycles per state; undefined, the LSU waits indefinitely.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  core,
  lsu_mem_if.master mem
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       st_wdata;
  logic [3:0]        st_wmask;
  logic [31:0]       ld_data;
  logic              tmo_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_tmo_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  lsu_lane_align u_align (
    .st_off_i   (core.req_addr[1:0]),
    .st_size_i  (core.req_size),
    .st_wdata_i (core.req_wdata),
    .st_wdata_o (st_wdata),
    .st_wmask_o (st_wmask),
    .ld_off_i   (addr_q[1:0]),
    .ld_size_i  (size_q),
    .ld_sext_i  (sext_q),
    .ld_rdata_i (mem.mem_rdata),
    .ld_data_o  (ld_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TMO_W   = (TMO_RAW < 8) ? 8 : TMO_RAW;

  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: restarts on every state change, counts while waiting.
  always_comb begin
    tmo_d = '0;
    if ((state_d == state_q) && ((state_q == ST_REQ) || (state_q == ST_WAIT_R)))
      tmo_d = tmo_q + 1'b1;
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and transaction-register update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    size_d  = size_q;
    sext_d  = sext_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (core.req_valid) begin
          addr_d  = core.req_addr;
          wen_d   = core.req_wen;
          size_d  = core.req_size;
          sext_d  = core.req_sext;
          wdata_d = st_wdata;
          wmask_d = st_wmask;
          rdata_d = '0;
          err_d   = access_bad(core.req_size, core.req_addr[1:0]);
          state_d = err_d ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem.mem_ready) begin
          if (wen_q) begin
            state_d = ST_RESP;
          end else if (mem.mem_rvalid) begin
            rdata_d = ld_data;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT_R;
          end
        end else if (tmo_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WAIT_R: begin
        if (mem.mem_rvalid) begin
          rdata_d = ld_data;
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (core.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and transaction registers; reset aborts any transaction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      size_q  <= SZ_B;
      sext_q  <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign core.req_ready  = (state_q == ST_IDLE);
  assign core.resp_valid = (state_q == ST_RESP);
  assign core.resp_rdata = rdata_q;
  assign core.resp_err   = err_q;

  assign mem.mem_valid = (state_q == ST_REQ);
  assign mem.mem_wen   = wen_q & (state_q == ST_REQ);
  assign mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wmask = {4'b0000, wmask_q};

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized self-checking bench for lsu_mem_master with an arithmetic
// reference model of address alignment, lane placement and extension.
module tb_lsu_mem_master;

`ifdef LSU_TIMEOUT_EN
  localparam int TB_TMO = 4;
  localparam int MAXLAT = 2;
`else
  localparam int TB_TMO = 255;
  localparam int MAXLAT = 5;
`endif

  logic clk;
  logic rst;

  lsu_req_if #(.ADDR_W(32), .DATA_W(32)) cif ();
  lsu_mem_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  lsu_mem_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (cif),
    .mem  (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference model: what the LSU should present, derived from sizes in bytes.
  function automatic void ref_model(
    input  bit          wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  bit          sext,
    input  logic [31:0] mrd,
    output bit          err,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    output logic [7:0]  mmask,
    output logic [31:0] rdata
  );
    int     nb;
    int     off;
    longint v;
    off = int'(addr % 4);
    case (size)
      2'd0:    nb = 1;
      2'd1:    nb = 2;
      2'd2:    nb = 4;
      default: nb = 0;
    endcase
    err   = (nb == 0) ? 1'b1 : ((off % nb) != 0);
    maddr = addr - 32'(off);
    mmask = (nb == 0) ? 8'h00 : 8'(((1 << nb) - 1) << off);
    if (nb == 1)      mwdata = (wdata & 32'h0000_00FF) * 32'h0101_0101;
    else if (nb == 2) mwdata = (wdata & 32'h0000_FFFF) * 32'h0001_0001;
    else              mwdata = wdata;
    if (err || wen) begin
      rdata = 32'h0;
    end else begin
      v = (longint'(mrd) >> (8 * off)) & ((64'd1 << (8 * nb)) - 1);
      if (sext && (v >= (64'd1 << (8 * nb - 1)))) v = v - (64'd1 << (8 * nb));
      rdata = 32'(v);
    end
  endfunction

  // One complete transaction with memory played by the bench. mlat cycles
  // before mem_ready, rlat cycles before mem_rvalid (unless same-cycle),
  // hold cycles of response backpressure.
  task automatic run_txn(
    input bit          wen,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [1:0]  size,
    input bit          sext,
    input logic [31:0] mrd,
    input int          mlat,
    input int          rlat,
    input bit          same,
    input int          hold
  );
    bit          e_err;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [7:0]  e_mask;
    ref_model(wen, addr, wdata, size, sext, mrd, e_err, e_addr, e_wd, e_mask, e_rd);

    check("req_ready_idle", 32'(cif.req_ready), 32'd1);
    cif.req_valid = 1'b1;
    cif.req_wen   = wen;
    cif.req_addr  = addr;
    cif.req_wdata = wdata;
    cif.req_size  = size;
    cif.req_sext  = sext;
    @(posedge clk);
    @(negedge clk);
    cif.req_valid = 1'b0;
    cif.req_addr  = $urandom;
    cif.req_wdata = $urandom;
    cif.req_size  = 2'($urandom_range(0, 3));
    cif.req_sext  = 1'($urandom_range(0, 1));

    if (!e_err) begin
      for (int i = 0; i < mlat; i++) begin
        check("mem_valid_wait", 32'(mif.mem_valid), 32'd1);
        check("req_ready_busy", 32'(cif.req_ready), 32'd0);
        check("resp_valid_early", 32'(cif.resp_valid), 32'd0);
        @(negedge clk);
      end
      check("mem_valid", 32'(mif.mem_valid), 32'd1);
      check("mem_addr", mif.mem_addr, e_addr);
      check("mem_wen", 32'(mif.mem_wen), 32'(wen));
      if (wen) begin
        check("mem_wmask", 32'(mif.mem_wmask), 32'(e_mask));
        check("mem_wdata", mif.mem_wdata, e_wd);
      end
      mif.mem_ready = 1'b1;
      if (!wen && same) begin
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = mrd;
      end
      @(posedge clk);
      @(negedge clk);
      mif.mem_ready  = 1'b0;
      mif.mem_rvalid = 1'b0;
      mif.mem_rdata  = $urandom;
      if (!wen && !same) begin
        for (int i = 0; i < rlat; i++) begin
          check("mem_valid_waitr", 32'(mif.mem_valid), 32'd0);
          check("resp_valid_waitr", 32'(cif.resp_valid), 32'd0);
          @(negedge clk);
        end
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = mrd;
        @(posedge clk);
        @(negedge clk);
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = $urandom;
      end
    end else begin
      check("err_no_mem_valid", 32'(mif.mem_valid), 32'd0);
    end

    for (int i = 0; i < hold; i++) begin
      check("resp_valid_hold", 32'(cif.resp_valid), 32'd1);
      check("resp_rdata_hold", cif.resp_rdata, e_rd);
      check("req_ready_hold", 32'(cif.req_ready), 32'd0);
      @(negedge clk);
    end
    check("resp_valid", 32'(cif.resp_valid), 32'd1);
    check("resp_rdata", cif.resp_rdata, e_rd);
    check("resp_err", 32'(cif.resp_err), 32'(e_err));
    check("resp_mem_valid", 32'(mif.mem_valid), 32'd0);
    cif.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cif.resp_ready = 1'b0;
    check("resp_valid_done", 32'(cif.resp_valid), 32'd0);
  endtask

  // Start a word load at addr and leave it just after the request handshake.
  task automatic start_load(input logic [31:0] addr);
    cif.req_valid = 1'b1;
    cif.req_wen   = 1'b0;
    cif.req_addr  = addr;
    cif.req_size  = 2'b10;
    cif.req_sext  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cif.req_valid = 1'b0;
  endtask

  initial begin
    bit          r_wen, r_sext, r_same;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_mrd;
    int          n_wait;

    rst            = 1'b1;
    cif.req_valid  = 1'b0;
    cif.req_wen    = 1'b0;
    cif.req_addr   = '0;
    cif.req_wdata  = '0;
    cif.req_size   = 2'b00;
    cif.req_sext   = 1'b0;
    cif.resp_ready = 1'b0;
    mif.mem_ready  = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = '0;
    #1;
    check("rst_req_ready", 32'(cif.req_ready), 32'd1);
    check("rst_mem_valid", 32'(mif.mem_valid), 32'd0);
    check("rst_mem_wen", 32'(mif.mem_wen), 32'd0);
    check("rst_resp_valid", 32'(cif.resp_valid), 32'd0);
    check("rst_resp_err", 32'(cif.resp_err), 32'd0);
    check("rst_mem_addr", mif.mem_addr, 32'd0);
    check("rst_mem_wdata", mif.mem_wdata, 32'd0);
    check("rst_mem_wmask", 32'(mif.mem_wmask), 32'd0);
    check("rst_resp_rdata", cif.resp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_txn(1'b1, 32'h8000_0003, 32'h0000_00AB, 2'b00, 1'b0, 32'h0, 3, 0, 1'b0, 0);
    run_txn(1'b0, 32'h8000_0002, 32'h0, 2'b01, 1'b1, 32'h8001_1234, 1, 2, 1'b0, 0);
    run_txn(1'b0, 32'h8000_0002, 32'h0, 2'b01, 1'b0, 32'h8001_1234, 0, 1, 1'b0, 0);
    run_txn(1'b0, 32'h8000_0002, 32'h0, 2'b10, 1'b0, 32'h1111_2222, 0, 0, 1'b0, 0);
    run_txn(1'b0, 32'h8000_0000, 32'h0, 2'b11, 1'b0, 32'h1111_2222, 0, 0, 1'b0, 0);
    run_txn(1'b0, 32'h8000_0001, 32'h0, 2'b00, 1'b1, 32'h00F0_0000, 2, 1, 1'b0, 5);
    run_txn(1'b1, 32'h0000_0010, 32'h1234_5678, 2'b10, 1'b0, 32'h0, 0, 0, 1'b0, 0);
    run_txn(1'b0, 32'h4000_0000, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, 0, 1'b1, 0);

    // Reset while the memory request is pending
    start_load(32'h8000_0100);
    check("pre_rst_mem_valid", 32'(mif.mem_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_req_mem_valid", 32'(mif.mem_valid), 32'd0);
    check("rst_req_req_ready", 32'(cif.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Reset while waiting for read data; the late read data must be ignored
    start_load(32'h8000_0200);
    mif.mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mif.mem_ready = 1'b0;
    check("waitr_mem_valid", 32'(mif.mem_valid), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_waitr_mem_valid", 32'(mif.mem_valid), 32'd0);
    check("rst_waitr_resp_valid", 32'(cif.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mif.mem_rvalid = 1'b1;
    mif.mem_rdata  = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    mif.mem_rvalid = 1'b0;
    check("stale_rvalid_resp", 32'(cif.resp_valid), 32'd0);
    check("stale_rvalid_ready", 32'(cif.req_ready), 32'd1);

`ifdef LSU_TIMEOUT_EN
    // Memory never answers: expect an error response after TB_TMO cycles
    start_load(32'h8000_0300);
    n_wait = 0;
    for (int i = 0; i < 4 * TB_TMO + 8; i++) begin
      if (cif.resp_valid) break;
      n_wait++;
      @(negedge clk);
    end
    check("tmo_cycles", 32'(n_wait), 32'(TB_TMO));
    check("tmo_resp_valid", 32'(cif.resp_valid), 32'd1);
    check("tmo_resp_err", 32'(cif.resp_err), 32'd1);
    check("tmo_resp_rdata", cif.resp_rdata, 32'd0);
    check("tmo_mem_valid", 32'(mif.mem_valid), 32'd0);
    cif.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cif.resp_ready = 1'b0;
`else
    n_wait = 0;
`endif

    // Randomized transactions
    for (int t = 0; t < 80; t++) begin
      r_wen   = 1'($urandom_range(0, 1));
      r_sext  = 1'($urandom_range(0, 1));
      r_same  = 1'($urandom_range(0, 1));
      r_size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_addr  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (r_size == 2'b01) r_addr[0] = 1'b0;
        if (r_size == 2'b10) r_addr[1:0] = 2'b00;
      end
      r_wdata = $urandom;
      r_mrd   = $urandom;
      run_txn(r_wen, r_addr, r_wdata, r_size, r_sext, r_mrd,
              $urandom_range(0, MAXLAT), $urandom_range(0, MAXLAT), r_same,
              $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
